// File: rtl/common_types.sv
// Shared fetch-path types: address/data widths, default queue depth and the
// fetch FSM state encoding.
package common_types;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam int unsigned FETCH_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REDIR
  } fst_t;

  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned depth);
    return idx % depth;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular byte queue for the fetch path: 1-byte push, 0-3 byte pop, flush.
// Exposes the three head bytes and the current occupancy.
module fetch_queue
  import common_types::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  data_t      push_data,
  input  logic [1:0] pop_cnt,
  output data_t      byte0,
  output data_t      byte1,
  output data_t      byte2,
  output logic [2:0] count
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  data_t          mem_q [DEPTH];
  logic [IW-1:0]  head_q, head_d;
  logic [IW-1:0]  tail_q, tail_d;
  logic [2:0]     count_q, count_d;

  always_comb begin
    head_d  = IW'(wrap_idx(32'(head_q) + 32'(pop_cnt), DEPTH));
    tail_d  = push ? IW'(wrap_idx(32'(tail_q) + 32'd1, DEPTH)) : tail_q;
    count_d = count_q + {2'b00, push} - {1'b0, pop_cnt};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; contents beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign byte0 = mem_q[IW'(wrap_idx(32'(head_q),         DEPTH))];
  assign byte1 = mem_q[IW'(wrap_idx(32'(head_q) + 32'd1, DEPTH))];
  assign byte2 = mem_q[IW'(wrap_idx(32'(head_q) + 32'd2, DEPTH))];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Byte fetch unit: FSM, fetch PC, in-flight tracking and sticky err around a
// fetch_queue. Optional stall counter output when FETCH_STALL_CNT_EN is defined.
module fetch_unit
  import common_types::*;
#(
  parameter addr_t       RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = FETCH_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  output addr_t      mem_addr,
  output logic       mem_rd,
  input  data_t      mem_data,
  input  logic       redirect,
  input  addr_t      redirect_pc,
  input  logic [1:0] consume,
  output data_t      q_byte0,
  output data_t      q_byte1,
  output data_t      q_byte2,
  output logic [2:0] q_count,
  output addr_t      q_pc,
  output logic       err
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  fst_t       state_q, state_d;
  addr_t      fpc_q, fpc_d;
  addr_t      q_pc_q, q_pc_d;
  logic       in_flight_q, in_flight_d;
  logic       err_q, err_d;
  logic       rd;
  logic       pop_ok;
  logic [1:0] pop_cnt;
  logic [3:0] occupancy;

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    q_pc_d      = q_pc_q;
    err_d       = err_q;
    occupancy   = {1'b0, q_count} + {3'b000, in_flight_q};
    rd          = rst_n && (state_q == RUN) && (occupancy < DEPTH_W);
    in_flight_d = rd;
    pop_ok      = ({1'b0, consume} <= q_count);
    pop_cnt     = (pop_ok && !redirect) ? consume : 2'd0;

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      REDIR:   state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (rd) fpc_d = fpc_q + 16'd1;
    q_pc_d = q_pc_q + 16'(pop_cnt);
    if (!pop_ok) err_d = 1'b1;

    // Redirect wins over everything: the read issued now is marked not in
    // flight, so its return next cycle is never pushed.
    if (redirect) begin
      state_d     = REDIR;
      fpc_d       = redirect_pc;
      q_pc_d      = redirect_pc;
      in_flight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fpc_q       <= RESET_PC;
      q_pc_q      <= RESET_PC;
      in_flight_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      q_pc_q      <= q_pc_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (in_flight_q),
    .push_data (mem_data),
    .pop_cnt   (pop_cnt),
    .byte0     (q_byte0),
    .byte1     (q_byte1),
    .byte2     (q_byte2),
    .count     (q_count)
  );

  assign mem_rd   = rd;
  assign mem_addr = fpc_q;
  assign q_pc     = q_pc_q;
  assign err      = err_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == RUN && q_count == 3'd0 && stall_q != '1) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based reference model predicts each
// cycle's outputs, a monitor on the falling edge compares them.
module tb_fetch_unit;
  import common_types::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  addr_t      mem_addr;
  logic       mem_rd;
  data_t      mem_data = '0;
  logic       redirect = 1'b0;
  addr_t      redirect_pc = '0;
  logic [1:0] consume = '0;
  data_t      q_byte0, q_byte1, q_byte2;
  logic [2:0] q_count;
  addr_t      q_pc;
  logic       err;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0200), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .consume     (consume),
    .q_byte0     (q_byte0),
    .q_byte1     (q_byte1),
    .q_byte2     (q_byte2),
    .q_count     (q_count),
    .q_pc        (q_pc),
    .err         (err)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Memory: byte returns one cycle after the read; garbage otherwise.
  data_t mem [65536];
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : data_t'($urandom);

  typedef struct {
    logic rd;
    int   addr;
    int   cnt;
    int   pc;
    int   b0, b1, b2;
    logic err;
    int   stall;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (start of the upcoming cycle).
  data_t mq[$];
  int    m_fpc, m_qpc, pend, phase, m_stall;  // phase: 0 after reset, 1 fetching, 2 bubble
  bit    m_err;

  task automatic model_reset();
    mq.delete();
    m_fpc = 16'h0200; m_qpc = 16'h0200; pend = -1; phase = 0; m_err = 0; m_stall = 0;
  endtask

  task automatic cycle(input bit rstn, input bit rdir, input int rpc, input int cons);
    exp_t e;
    int arriving;
    @(posedge clk); #1;
    rst_n = rstn; redirect = rdir; redirect_pc = addr_t'(rpc); consume = 2'(cons);
    e.rd    = rstn && phase == 1 && (mq.size() + ((pend >= 0) ? 1 : 0)) < 4;
    e.addr  = m_fpc;
    e.cnt   = mq.size();
    e.pc    = m_qpc;
    e.b0    = (mq.size() > 0) ? int'(mq[0]) : 0;
    e.b1    = (mq.size() > 1) ? int'(mq[1]) : 0;
    e.b2    = (mq.size() > 2) ? int'(mq[2]) : 0;
    e.err   = m_err;
    e.stall = m_stall;
    exp_q.push_back(e);
    if (!rstn) begin
      model_reset();
    end else begin
      arriving = pend;
      pend = e.rd ? m_fpc : -1;
      if (cons > mq.size()) m_err = 1;
      if (phase == 1 && mq.size() == 0 && m_stall < 65535) m_stall++;
      if (rdir) begin
        mq.delete(); m_qpc = rpc; m_fpc = rpc; pend = -1; phase = 2;
      end else begin
        if (cons <= mq.size()) begin
          repeat (cons) void'(mq.pop_front());
          m_qpc = (m_qpc + cons) & 16'hFFFF;
        end
        if (arriving >= 0) mq.push_back(mem[arriving]);
        if (e.rd) m_fpc = (m_fpc + 1) & 16'hFFFF;
        phase = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_rd", int'(mem_rd), int'(e.rd));
        if (e.rd) chk("mem_addr", int'(mem_addr), e.addr);
        chk("q_count", int'(q_count), e.cnt);
        chk("q_pc", int'(q_pc), e.pc);
        if (e.cnt > 0) chk("q_byte0", int'(q_byte0), e.b0);
        if (e.cnt > 1) chk("q_byte1", int'(q_byte1), e.b1);
        if (e.cnt > 2) chk("q_byte2", int'(q_byte2), e.b2);
        chk("err", int'(err), int'(e.err));
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt), e.stall);
`endif
      end
    end
  end

  int guard;
  int c;
  int mx;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = data_t'($urandom);
    mem[16'h0200] = 8'hA2; mem[16'h0201] = 8'h05; mem[16'h0202] = 8'hE8; mem[16'h0203] = 8'hEA;
    model_reset();

    // Reset, then fill with no consumption: four reads then stop.
    repeat (2) cycle(0, 0, 0, 0);
    repeat (8) cycle(1, 0, 0, 0);

    // Steady stream, one pop per cycle whenever data is present.
    repeat (30) cycle(1, 0, 0, (mq.size() >= 1) ? 1 : 0);

    // Three queued with a push landing, pop two.
    guard = 0;
    while (!(mq.size() == 3 && pend >= 0) && guard < 10) begin
      cycle(1, 0, 0, 0); guard++;
    end
    cycle(1, 0, 0, 2);
    repeat (3) cycle(1, 0, 0, 0);

    // Redirect with a read in flight.
    guard = 0;
    while (pend < 0 && guard < 10) begin
      cycle(1, 0, 0, (mq.size() >= 1) ? 1 : 0); guard++;
    end
    cycle(1, 1, 16'h1234, 0);
    repeat (6) cycle(1, 0, 0, 0);

    // Wrap through FFFF.
    cycle(1, 1, 16'hFFFE, 0);
    repeat (6) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 2);
    repeat (3) cycle(1, 0, 0, (mq.size() >= 1) ? 1 : 0);

    // Back-to-back redirects.
    cycle(1, 1, 16'h3000, 0);
    cycle(1, 1, 16'h4000, 0);
    repeat (5) cycle(1, 0, 0, 0);

    // Randomized legal traffic with occasional redirects and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      mx = (mq.size() < 3) ? mq.size() : 3;
      c  = $urandom_range(mx, 0);
      if (i == 150) cycle(0, 0, 0, 0);
      else if ($urandom_range(15, 0) == 0)
        cycle(1, 1, ($urandom_range(1, 0) == 1) ? int'($urandom_range(16'hFFFF, 16'hFFFC)) : int'($urandom_range(16'hFFFF, 0)), c);
      else cycle(1, 0, 0, c);
    end

    // Illegal consume at q_count=1: no pop, sticky err until reset.
    cycle(1, 1, 16'h5000, 0);
    guard = 0;
    while (mq.size() != 1 && guard < 20) begin
      cycle(1, 0, 0, 0); guard++;
    end
    cycle(1, 0, 0, 3);
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    repeat (2) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    repeat (4) cycle(1, 0, 0, 0);

    @(posedge clk); @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
